// File: rtl/light_pattern_seq.sv
// Pattern table light sequencer with auto-forward/reverse, hold and manual step modes.
// Build option DEFAULT_PATTERNS_EN: table resets to the 95/A9, A9/95, 99/99, A5/A5 set instead of zeros.
module light_pattern_seq #(
    parameter int WIDTH   = 8,
    parameter int NUM_PAT = 4,
    parameter int TICKS   = 6250000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_green,
    input  logic [WIDTH-1:0] wr_red,
    output logic [WIDTH-1:0] green,
    output logic [WIDTH-1:0] red,
    output logic [3:0]       pat_idx,
    output logic             adv
);

    localparam int IW = $clog2(NUM_PAT);
    localparam int PW = $clog2(TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_PAT - 1);

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;

`ifdef DEFAULT_PATTERNS_EN
    function automatic logic [WIDTH-1:0] dflt_g(input int k);
        logic [7:0] v;
        case (k % 4)
            0:       v = 8'h95;
            1:       v = 8'hA9;
            2:       v = 8'h99;
            default: v = 8'hA5;
        endcase
        return WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] dflt_r(input int k);
        logic [7:0] v;
        case (k % 4)
            0:       v = 8'hA9;
            1:       v = 8'h95;
            2:       v = 8'h99;
            default: v = 8'hA5;
        endcase
        return WIDTH'(v);
    endfunction
`endif

    logic [WIDTH-1:0] tbl_g [NUM_PAT];
    logic [WIDTH-1:0] tbl_r [NUM_PAT];

    logic [PW-1:0] presc, presc_nxt;
    logic [IW-1:0] idx, idx_nxt, idx_fwd, idx_rev;
    logic          adv_nxt;
    logic          step_d;
    logic          step_rise;

    assign step_rise = step & ~step_d;
    assign idx_fwd   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    assign idx_rev   = (idx == '0) ? IDX_LAST : idx - IW'(1);
    assign pat_idx   = 4'(idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            idx    <= '0;
            adv    <= 1'b0;
            step_d <= 1'b0;
        end else begin
            presc  <= presc_nxt;
            idx    <= idx_nxt;
            adv    <= adv_nxt;
            step_d <= step;
        end
    end

    // Disable parks at entry 0 silently; adv only marks real advances.
    always_comb begin
        presc_nxt = presc;
        idx_nxt   = idx;
        adv_nxt   = 1'b0;
        if (!enable) begin
            presc_nxt = '0;
            idx_nxt   = '0;
        end else begin
            case (mode)
                MODE_FWD, MODE_REV: begin
                    if (presc == PRESC_LAST) begin
                        presc_nxt = '0;
                        idx_nxt   = (mode == MODE_REV) ? idx_rev : idx_fwd;
                        adv_nxt   = 1'b1;
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                MODE_HOLD: begin
                    presc_nxt = presc;
                end
                default: begin
                    presc_nxt = '0;
                    if (step_rise) begin
                        idx_nxt = idx_fwd;
                        adv_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Addresses beyond the table never match any entry, so they are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_PAT; k++) begin
`ifdef DEFAULT_PATTERNS_EN
                tbl_g[k] <= dflt_g(k);
                tbl_r[k] <= dflt_r(k);
`else
                tbl_g[k] <= '0;
                tbl_r[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < NUM_PAT; k++) begin
                if (wr_en && (wr_addr == 4'(k))) begin
                    tbl_g[k] <= wr_green;
                    tbl_r[k] <= wr_red;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
`ifdef DEFAULT_PATTERNS_EN
            green <= dflt_g(0);
            red   <= dflt_r(0);
`else
            green <= '0;
            red   <= '0;
`endif
        end else begin
            green <= tbl_g[idx];
            red   <= tbl_r[idx];
        end
    end

endmodule

// File: tb/tb_light_pattern_seq.sv
// Directed bench for light_pattern_seq (WIDTH=8, NUM_PAT=4, TICKS=4); works with or without DEFAULT_PATTERNS_EN.
module tb_light_pattern_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       step;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_green;
    logic [7:0] wr_red;
    logic [7:0] green;
    logic [7:0] red;
    logic [3:0] pat_idx;
    logic       adv;

    int total = 0;
    int bad   = 0;
    int adv_cnt;

    logic [7:0] eg [4] = '{8'h95, 8'hA9, 8'h99, 8'hA5};
    logic [7:0] er [4] = '{8'hA9, 8'h95, 8'h99, 8'hA5};

`ifdef DEFAULT_PATTERNS_EN
    localparam logic [7:0] RST_G0 = 8'h95;
    localparam logic [7:0] RST_R0 = 8'hA9;
    localparam logic [7:0] RST_G1 = 8'hA9;
`else
    localparam logic [7:0] RST_G0 = 8'h00;
    localparam logic [7:0] RST_R0 = 8'h00;
    localparam logic [7:0] RST_G1 = 8'h00;
`endif

    light_pattern_seq #(.WIDTH(8), .NUM_PAT(4), .TICKS(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .step(step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_green(wr_green), .wr_red(wr_red),
        .green(green), .red(red), .pat_idx(pat_idx), .adv(adv)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 2'b00; step = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_green = 8'h00; wr_red = 8'h00;
        #12;
        chk("rst_idx",   32'(pat_idx), 32'h0);
        chk("rst_adv",   32'(adv),     32'h0);
        chk("rst_green", 32'(green),   32'(RST_G0));
        chk("rst_red",   32'(red),     32'(RST_R0));
        cyc();
        reset = 1'b1;

        // load the standard patterns (harmless when they are already the reset set)
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_green = eg[k]; wr_red = er[k];
            cyc();
        end
        wr_en = 1'b0;
        cyc();
        chk("load_green", 32'(green), 32'h95);
        chk("load_red",   32'(red),   32'hA9);

        // auto-forward
        enable = 1'b1; mode = 2'b00;
        for (int s = 1; s <= 4; s++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 1) chk("fwd_green", 32'(green), 32'(eg[(s - 1) % 4]));
                if (c < 4) begin
                    chk("fwd_adv_lo", 32'(adv),     32'h0);
                    chk("fwd_idx_hold", 32'(pat_idx), 32'((s - 1) % 4));
                end else begin
                    chk("fwd_idx", 32'(pat_idx), 32'(s % 4));
                    chk("fwd_adv", 32'(adv),     32'h1);
                end
            end
        end
        cyc();
        chk("fwd_wrap_green", 32'(green), 32'h95);
        enable = 1'b0;
        cyc();

        // auto-reverse from index 0
        enable = 1'b1; mode = 2'b01;
        for (int s = 1; s <= 4; s++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 1) chk("rev_red", 32'(red), 32'(er[(4 - (s - 1)) % 4]));
                if (c < 4) chk("rev_adv_lo", 32'(adv), 32'h0);
                else begin
                    chk("rev_idx", 32'(pat_idx), 32'((4 - s) % 4));
                    chk("rev_adv", 32'(adv),     32'h1);
                end
            end
        end
        cyc();
        chk("rev_end_red", 32'(red), 32'hA9);

        // hold freezes prescaler at 1; forward resumes and ticks after 3 more clocks
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_idx", 32'(pat_idx), 32'h0);
            chk("hold_adv", 32'(adv),     32'h0);
        end
        mode = 2'b00;
        cyc(); chk("resume_idx_a", 32'(pat_idx), 32'h0);
        cyc(); chk("resume_idx_b", 32'(pat_idx), 32'h0);
        cyc(); chk("resume_idx_c", 32'(pat_idx), 32'h1);
        chk("resume_adv", 32'(adv), 32'h1);

        // enable-forced return to 0 without adv
        enable = 1'b0;
        cyc();
        chk("dis_idx", 32'(pat_idx), 32'h0);
        chk("dis_adv", 32'(adv),     32'h0);

        // manual stepping
        enable = 1'b1; mode = 2'b11; step = 1'b0;
        cyc();
        adv_cnt = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            adv_cnt += int'(adv);
            chk("man_idx1", 32'(pat_idx), 32'h1);
            chk("man_adv1", 32'(adv),     (i == 0) ? 32'h1 : 32'h0);
        end
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            adv_cnt += int'(adv);
            chk("man_idx_low", 32'(pat_idx), 32'h1);
        end
        step = 1'b1;
        cyc(); adv_cnt += int'(adv);
        chk("man_idx2", 32'(pat_idx), 32'h2);
        cyc(); adv_cnt += int'(adv);
        chk("man_adv2_lo", 32'(adv), 32'h0);
        chk("man_adv_count", 32'(adv_cnt), 32'd2);

        // write displayed entry, then an out-of-range address
        wr_en = 1'b1; wr_addr = 4'd2; wr_green = 8'hFF; wr_red = 8'h00;
        cyc();
        wr_en = 1'b0;
        cyc();
        chk("wr_green", 32'(green), 32'hFF);
        chk("wr_red",   32'(red),   32'h00);
        wr_en = 1'b1; wr_addr = 4'd5; wr_green = 8'h11; wr_red = 8'h22;
        cyc();
        wr_en = 1'b0;
        cyc();
        chk("oob_green", 32'(green), 32'hFF);
        chk("oob_red",   32'(red),   32'h00);

        step = 1'b0; cyc();
        step = 1'b1; cyc();
        chk("man_idx3", 32'(pat_idx), 32'h3);
        cyc();
        chk("idx3_green", 32'(green), 32'hA5);

        // disable at index 3
        enable = 1'b0;
        cyc();
        chk("dis3_idx", 32'(pat_idx), 32'h0);
        chk("dis3_adv", 32'(adv),     32'h0);
        cyc();
        chk("dis3_green", 32'(green), 32'h95);

        // entry 1 untouched by the address-5 write
        enable = 1'b1; mode = 2'b11;
        step = 1'b0; cyc();
        step = 1'b1; cyc();
        chk("e1_idx", 32'(pat_idx), 32'h1);
        cyc();
        chk("e1_green", 32'(green), 32'hA9);
        chk("e1_red",   32'(red),   32'h95);

        // write coincident with advance into the written entry
        step = 1'b0; cyc();
        step = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_green = 8'h3C; wr_red = 8'hC3;
        cyc();
        wr_en = 1'b0;
        chk("co_idx", 32'(pat_idx), 32'h2);
        chk("co_adv", 32'(adv),     32'h1);
        cyc();
        chk("co_green", 32'(green), 32'h3C);
        chk("co_red",   32'(red),   32'hC3);

        // reset mid-count: prescaler at 2 when reset hits
        step = 1'b0; mode = 2'b00;
        cyc(); cyc();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_idx",   32'(pat_idx), 32'h0);
        chk("mid_rst_adv",   32'(adv),     32'h0);
        chk("mid_rst_green", 32'(green),   32'(RST_G0));
        chk("mid_rst_red",   32'(red),     32'(RST_R0));
        #2 reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step = ~step;
            cyc();
            if (c < 4) chk("post_rst_idx0", 32'(pat_idx), 32'h0);
            else begin
                chk("post_rst_idx1", 32'(pat_idx), 32'h1);
                chk("post_rst_adv",  32'(adv),     32'h1);
            end
        end
        cyc();
        chk("post_rst_green", 32'(green), 32'(RST_G1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
